// File: rtl/slice_sched_pkg.sv
// rtl/slice_sched_pkg.sv - shared types, constants and round-robin pick helper for slice_rr_scheduler
package slice_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int GRANT_CNT_W = 16;
    localparam int MAX_REQ     = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } pick_t;

    // First set bit strictly after ptr, wrapping; ptr itself is visited last.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 n_req);
        pick_t p;
        int    idx;
        p = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n_req;
            if (i <= n_req && !p.valid && req[4'(idx)]) begin
                p.valid = 1'b1;
                p.idx   = 4'(idx);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/slice_counter.sv
// rtl/slice_counter.sv - slice counter with sync clear and runtime final value
module slice_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_en,
    input  logic            i_clr,
    input  logic [BITS-1:0] i_final,
    output logic [BITS-1:0] o_count,
    output logic            o_done
);

    logic [BITS-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == i_final);

endmodule

// File: rtl/slice_rr_scheduler.sv
// rtl/slice_rr_scheduler.sv - time-slice round-robin scheduler; optional SLICE_RR_GRANT_COUNT_EN adds grant_total
module slice_rr_scheduler
    import slice_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int BITS  = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] release_i,
    input  logic [BITS-1:0]  slice_len,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic [BITS-1:0]  slice_cnt
`ifdef SLICE_RR_GRANT_COUNT_EN
    ,
    output logic [GRANT_CNT_W-1:0] grant_total
`endif
);

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_ptr;
    logic [BITS-1:0]    r_slice_final;

    logic [MAX_REQ-1:0] w_req_ext;
    logic [3:0]         w_search_ptr;
    pick_t              w_pick;
    logic               w_in_grant;
    logic               w_slice_end;
    logic               w_start;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_done;
    logic [BITS-1:0]    w_cnt;

    assign w_in_grant   = (r_state == GRANT);
    assign w_req_ext    = MAX_REQ'(req);
    // At slice end the search starts after the current owner, so it is re-picked only if alone.
    assign w_search_ptr = w_in_grant ? 4'(r_grant_id) : 4'(r_ptr);
    assign w_pick       = rr_pick(w_req_ext, w_search_ptr, N_REQ);

    assign w_slice_end  = w_in_grant &
                          (w_done | ~req[r_grant_id] | release_i[r_grant_id]);
    assign w_start      = enable & w_pick.valid & (~w_in_grant | w_slice_end);
    assign w_cnt_clr    = enable & (~w_in_grant | w_slice_end);
    assign w_cnt_en     = enable & w_in_grant & ~w_slice_end;

    slice_counter #(
        .BITS (BITS)
    ) u_slice_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_cnt_en),
        .i_clr   (w_cnt_clr),
        .i_final (r_slice_final),
        .o_count (w_cnt),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_ptr         <= ID_W'(N_REQ - 1);
            r_slice_final <= '0;
        end else if (enable) begin
            if (w_slice_end) begin
                r_ptr <= r_grant_id;
            end
            if (w_start) begin
                r_state       <= GRANT;
                r_grant       <= N_REQ'(1) << w_pick.idx;
                r_grant_id    <= ID_W'(w_pick.idx);
                r_slice_final <= slice_len;
            end else if (~w_in_grant | w_slice_end) begin
                r_state    <= IDLE;
                r_grant    <= '0;
                r_grant_id <= '0;
            end
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign busy      = w_in_grant;
    assign slice_cnt = w_cnt;

`ifdef SLICE_RR_GRANT_COUNT_EN
    logic [GRANT_CNT_W-1:0] r_grant_total;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_total <= '0;
        end else if (w_start && (r_grant_total != '1)) begin
            r_grant_total <= r_grant_total + 1'b1;
        end
    end

    assign grant_total = r_grant_total;
`endif

endmodule

// File: tb/tb_slice_rr_scheduler.sv
// tb/tb_slice_rr_scheduler.sv - table-driven scoreboard bench for slice_rr_scheduler
module tb_slice_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int BITS  = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] release_i = '0;
    logic [BITS-1:0]  slice_len = '0;
    logic [N_REQ-1:0] grant;
    logic [1:0]       grant_id;
    logic             busy;
    logic [BITS-1:0]  slice_cnt;
`ifdef SLICE_RR_GRANT_COUNT_EN
    logic [15:0]      grant_total;
`endif

    slice_rr_scheduler #(
        .N_REQ (N_REQ),
        .BITS  (BITS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req),
        .release_i (release_i),
        .slice_len (slice_len),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .slice_cnt (slice_cnt)
`ifdef SLICE_RR_GRANT_COUNT_EN
        ,
        .grant_total (grant_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] rq;
        logic [3:0] rel;
        logic [3:0] slen;
        logic [3:0] g;
        logic [1:0] id;
        bit         bsy;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        bit         bsy;
        logic [3:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;

    function automatic void add(bit rst, bit en, logic [3:0] rq, logic [3:0] rel, logic [3:0] slen,
                                logic [3:0] g, logic [1:0] id, bit bsy, logic [3:0] cnt);
        vec_t v;
        v = '{rst, en, rq, rel, slen, g, id, bsy, cnt};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, cur, act, expv);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check("grant",     32'(grant),     32'(e.g));
        check("grant_id",  32'(grant_id),  32'(e.id));
        check("busy",      32'(busy),      32'(e.bsy));
        check("slice_cnt", 32'(slice_cnt), 32'(e.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;

        // single requester, slice of 4 then re-grant; enable low in IDLE holds off the grant
        add(1, 1, 4'b0001, 4'b0000, 4'd3, 4'b0000, 2'd0, 0, 4'd0);
        add(0, 0, 4'b0001, 4'b0000, 4'd3, 4'b0000, 2'd0, 0, 4'd0);
        add(0, 1, 4'b0001, 4'b0000, 4'd3, 4'b0001, 2'd0, 1, 4'd0);
        add(0, 1, 4'b0001, 4'b0000, 4'd3, 4'b0001, 2'd0, 1, 4'd1);
        add(0, 1, 4'b0001, 4'b0000, 4'd3, 4'b0001, 2'd0, 1, 4'd2);
        add(0, 1, 4'b0001, 4'b0000, 4'd3, 4'b0001, 2'd0, 1, 4'd3);
        add(0, 1, 4'b0001, 4'b0000, 4'd3, 4'b0001, 2'd0, 1, 4'd0);
        add(0, 1, 4'b0001, 4'b0000, 4'd3, 4'b0001, 2'd0, 1, 4'd1);

        // all four requesting, 2-cycle slices rotate with no bubble
        add(1, 1, 4'b1111, 4'b0000, 4'd1, 4'b0000, 2'd0, 0, 4'd0);
        for (int s = 0; s < 10; s++) begin
            k = (s / 2) % 4;
            add(0, 1, 4'b1111, 4'b0000, 4'd1, 4'(1 << k), 2'(k), 1, 4'(s % 2));
        end

        // slice_len=0: rotate every cycle
        add(1, 1, 4'b0011, 4'b0000, 4'd0, 4'b0000, 2'd0, 0, 4'd0);
        for (int s = 0; s < 4; s++) begin
            add(0, 1, 4'b0011, 4'b0000, 4'd0, 4'(1 << (s % 2)), 2'(s % 2), 1, 4'd0);
        end

        // early release of the owner; release of a non-owner ignored; then enable freeze
        add(1, 1, 4'b0101, 4'b0000, 4'd7, 4'b0000, 2'd0, 0, 4'd0);
        add(0, 1, 4'b0101, 4'b0000, 4'd7, 4'b0001, 2'd0, 1, 4'd0);
        add(0, 1, 4'b0101, 4'b0000, 4'd7, 4'b0001, 2'd0, 1, 4'd1);
        add(0, 1, 4'b0101, 4'b0000, 4'd7, 4'b0001, 2'd0, 1, 4'd2);
        add(0, 1, 4'b0101, 4'b0011, 4'd7, 4'b0100, 2'd2, 1, 4'd0);
        add(0, 1, 4'b0101, 4'b0010, 4'd7, 4'b0100, 2'd2, 1, 4'd1);
        add(0, 1, 4'b0101, 4'b0000, 4'd7, 4'b0100, 2'd2, 1, 4'd2);
        for (int s = 0; s < 5; s++) begin
            add(0, 0, 4'b0000, 4'b0100, 4'd7, 4'b0100, 2'd2, 1, 4'd2);
        end
        add(0, 1, 4'b0101, 4'b0000, 4'd7, 4'b0100, 2'd2, 1, 4'd3);

        // owner drops its request: back to IDLE, later re-picked from IDLE
        add(1, 1, 4'b0010, 4'b0000, 4'd3, 4'b0000, 2'd0, 0, 4'd0);
        add(0, 1, 4'b0010, 4'b0000, 4'd3, 4'b0010, 2'd1, 1, 4'd0);
        add(0, 1, 4'b0010, 4'b0000, 4'd3, 4'b0010, 2'd1, 1, 4'd1);
        add(0, 1, 4'b0000, 4'b0000, 4'd3, 4'b0000, 2'd0, 0, 4'd0);
        add(0, 1, 4'b0010, 4'b0000, 4'd3, 4'b0010, 2'd1, 1, 4'd0);
        add(0, 1, 4'b0010, 4'b0000, 4'd3, 4'b0010, 2'd1, 1, 4'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            cur       = i;
            reset_n   = !vecs[i].rst;
            enable    = vecs[i].en;
            req       = vecs[i].rq;
            release_i = vecs[i].rel;
            slice_len = vecs[i].slen;
            exp_q.push_back('{vecs[i].g, vecs[i].id, vecs[i].bsy, vecs[i].cnt});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_outputs(e);
        end

        // asynchronous reset mid-slice, between clock edges
        cur = vecs.size();
        #2;
        reset_n = 1'b0;
        #1;
        e = '{4'b0000, 2'd0, 1'b0, 4'd0};
        check_outputs(e);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef SLICE_RR_GRANT_COUNT_EN
        cur = cur + 1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("grant_total_reset", 32'(grant_total), 32'd0);
        reset_n   = 1'b1;
        enable    = 1'b1;
        req       = 4'b0011;
        release_i = 4'b0000;
        slice_len = 4'd0;
        repeat (10) @(posedge clk);
        #1;
        check("grant_total_10", 32'(grant_total), 32'd10);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("grant_total_hold", 32'(grant_total), 32'd10);
        @(negedge clk);
        force dut.r_grant_total = 16'hFFFD;
        #1;
        release dut.r_grant_total;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("grant_total_sat", 32'(grant_total), 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_rr_scheduler.md
Name: slice_rr_scheduler

Overview:
- Time-slice round-robin scheduler that shares one modulo slice counter between N_REQ requesters.
- Grants one requester at a time for a runtime-programmable slice of slice_len+1 enabled cycles, then rotates to the next active requester.
- Sits in front of shared datapath resources; the grant vector drives their enables.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- BITS, 4, slice counter width.
- ID_W, $clog2(N_REQ), grant index width (derived; do not override).

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  global advance; low freezes all state.
- req  input  N_REQ  per-requester request level.
- release_i  input  N_REQ  per-requester early slice release (pulse); only the granted bit is honoured.
- slice_len  input  BITS  final count value; a slice lasts slice_len+1 enabled cycles.
- grant  output  N_REQ  one-hot grant, registered.
- grant_id  output  ID_W  index of the granted requester; 0 when idle.
- busy  output  1  high in state GRANT.
- slice_cnt  output  BITS  current slice count.

Behaviour:
- Reset values: state IDLE, grant=0, grant_id=0, busy=0, slice_cnt=0, rr pointer=N_REQ-1 (first search starts at requester 0).
- FSM states: IDLE, GRANT.
- IDLE, with enable=1 and |req=1:
  - Select the first set req bit searching upward from pointer+1, with wrap-around.
  - Next cycle: grant/grant_id/busy asserted, slice_cnt=0, slice_len latched into slice_final.
  - Latency from req to grant is exactly 1 cycle.
- GRANT, with enable=1: slice_cnt increments each cycle. The slice ends when any of the following holds in the current cycle:
  - slice_cnt==slice_final;
  - req[grant_id]==0;
  - release_i[grant_id]==1.
- At slice end:
  - Pointer is set to grant_id.
  - If any req is set, excluding the current requester when it is dropping (req low), go directly to the next winner the following cycle. There is no idle bubble; slice_cnt and slice_final are reloaded.
  - If only the current requester remains (req high, slice expired or released), it is re-granted with a fresh slice.
  - Otherwise go to IDLE; grant=0, grant_id=0, slice_cnt=0.
- enable=0: state, counter, pointer and grant all hold; req/release_i are ignored in that cycle.
- slice_len changes mid-slice take effect only at the next grant.
- slice_len=0 gives 1-cycle slices, with back-to-back rotation every cycle.
- Counter wrap: cannot occur, because the end condition triggers at slice_final ≤ 2^BITS−1.
- Invariants:
  - grant is one-hot or zero; never multi-hot.
  - Asynchronous reset mid-slice immediately returns all outputs to their reset values.

Optional Feature:
- Macro: SLICE_RR_GRANT_COUNT_EN.
- With it defined:
  - Adds output grant_total [15:0], counting each new slice start (including re-grants).
  - Saturates at 16'hFFFF.
  - Resets to 0.
  - Holds while enable=0.
- Without it: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package slice_sched_pkg:
  - state typedef (IDLE=1'b0, GRANT=1'b1);
  - GRANT_CNT_W=16 constant;
  - function rr_pick(req, ptr) returning the winner index and a valid flag.
- Sub-module slice_counter:
  - BITS-wide modulo counter;
  - inputs: enable, sync clear, runtime final value;
  - output: done = (count==final).
- The scheduler instantiates one slice_counter.

Test Plan:
1. Reset release, N_REQ=4, req=4'b0001, slice_len=3:
   - grant=0001 one cycle after req;
   - slice_cnt runs 0,1,2,3;
   - re-grant of 0001 with slice_cnt=0 on the next cycle.
2. req=4'b1111, slice_len=1:
   - grant sequence 0001,0010,0100,1000,0001, each held exactly 2 cycles;
   - busy stays high with no bubble.
3. req=4'b0101, slice_len=7:
   - requester 0 granted; release_i[0] pulsed at slice_cnt=2;
   - next cycle grant=0100, slice_cnt=0;
   - release_i[1] pulsed during the same window is ignored.
4. enable held low for 5 cycles mid-slice at slice_cnt=2:
   - slice_cnt, grant and grant_id constant;
   - on enable high, counting resumes at 3.
5. req=4'b0010 alone; drop req[1] at slice_cnt=1:
   - next cycle IDLE: grant=0, grant_id=0, busy=0, slice_cnt=0.
   - Assert reset_n low mid-slice: outputs clear asynchronously.
6. With SLICE_RR_GRANT_COUNT_EN defined, req=4'b0011, slice_len=0, 10 enabled cycles:
   - grant_total=10;
   - forced near 16'hFFFF, it saturates and does not wrap.
